// File: rtl/ppi_8255_sync.sv
// Clocked 8255-style parallel interface: Mode 0 I/O, Mode 1 strobed handshakes on
// ports A/B, port C bit set/reset, split-direction pins with tristates left to the pads.
module ppi_8255_sync #(
    parameter int unsigned W           = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CS_n,
    input  logic         RD_n,
    input  logic         WR_n,
    input  logic [1:0]   A,
    input  logic [W-1:0] D_IN,
    output logic [W-1:0] D_OUT,
    output logic         D_OE,
    input  logic [W-1:0] PA_IN,
    input  logic [W-1:0] PB_IN,
    output logic [W-1:0] PA_OUT,
    output logic [W-1:0] PB_OUT,
    output logic         PA_OE,
    output logic         PB_OE,
    input  logic [7:0]   PC_IN,
    output logic [7:0]   PC_OUT,
    output logic [7:0]   PC_OE,
    output logic         INTR_A,
    output logic         INTR_B
);
    logic [7:0]   ctrl;
    logic [W-1:0] pa_q, pb_q;
    logic [7:0]   pc_q;
    logic         ibf_a, ibf_b, obf_a_n, obf_b_n;
    logic         intr_a, intr_b, inte_a, inte_b;
    logic         wr_prev, rd_prev;

    // Handshake inputs: [0] = PC4 (STB_A_n), [1] = PC6 (ACK_A_n), [2] = PC2 (STB_B_n / ACK_B_n)
    logic [2:0][SYNC_STAGES-1:0] sync_q;
    logic [2:0] hs_pins, hs_now, hs_prev, hs_fall, hs_rise;

    logic mode_a, mode_b, pa_in_dir, pb_in_dir, pcu_in, pcl_in;
    logic wr_ev, rd_fall, rd_rise;
    logic wr_pa, wr_pb, wr_pc, wr_ctrl, wr_bsr;
    logic rd_fall_a, rd_rise_a, rd_fall_b, rd_rise_b;
    logic [2:0] bsr_bit, inte_a_pos;
    logic [7:0] owned, pc_oe_m0, pc_rd;
    logic [W-1:0] rdata;

    assign mode_a    = |ctrl[6:5];
    assign pa_in_dir = ctrl[4];
    assign pcu_in    = ctrl[3];
    assign mode_b    = ctrl[2];
    assign pb_in_dir = ctrl[1];
    assign pcl_in    = ctrl[0];

    assign wr_ev   = ~CS_n & ~WR_n & wr_prev;
    assign rd_fall = ~CS_n & ~RD_n & rd_prev;
    assign rd_rise = ~CS_n & RD_n & ~rd_prev;

    assign wr_pa   = wr_ev & (A == 2'b00);
    assign wr_pb   = wr_ev & (A == 2'b01);
    assign wr_pc   = wr_ev & (A == 2'b10);
    assign wr_ctrl = wr_ev & (A == 2'b11) & D_IN[7];
    assign wr_bsr  = wr_ev & (A == 2'b11) & ~D_IN[7];

    assign rd_fall_a = rd_fall & (A == 2'b00);
    assign rd_rise_a = rd_rise & (A == 2'b00);
    assign rd_fall_b = rd_fall & (A == 2'b01);
    assign rd_rise_b = rd_rise & (A == 2'b01);

    assign bsr_bit    = D_IN[3:1];
    assign inte_a_pos = pa_in_dir ? 3'd4 : 3'd6;

    assign hs_pins = {PC_IN[2], PC_IN[6], PC_IN[4]};
    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            hs_now[k] = sync_q[k][SYNC_STAGES-1];
        end
    end
    assign hs_fall = hs_prev & ~hs_now;
    assign hs_rise = ~hs_prev & hs_now;

    // Port C bits taken over by the Mode 1 handshake of either group
    always_comb begin
        owned = '0;
        if (mode_a) owned = owned | (pa_in_dir ? 8'h38 : 8'hC8);
        if (mode_b) owned = owned | 8'h07;
    end

    assign pc_oe_m0 = {{4{~pcu_in}}, {4{~pcl_in}}};

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ctrl    <= 8'h9B;
            pa_q    <= '0;
            pb_q    <= '0;
            pc_q    <= '0;
            ibf_a   <= 1'b0;
            ibf_b   <= 1'b0;
            obf_a_n <= 1'b1;
            obf_b_n <= 1'b1;
            intr_a  <= 1'b0;
            intr_b  <= 1'b0;
            inte_a  <= 1'b0;
            inte_b  <= 1'b0;
            wr_prev <= 1'b1;
            rd_prev <= 1'b1;
            sync_q  <= '1;
            hs_prev <= '1;
        end else begin
            wr_prev <= WR_n;
            rd_prev <= RD_n;
            hs_prev <= hs_now;
            for (int unsigned k = 0; k < 3; k++) begin
                sync_q[k][0] <= hs_pins[k];
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[k][i] <= sync_q[k][i-1];
                end
            end

            if (wr_ctrl) begin
                ctrl    <= D_IN[7:0];
                pa_q    <= '0;
                pb_q    <= '0;
                pc_q    <= '0;
                ibf_a   <= 1'b0;
                ibf_b   <= 1'b0;
                obf_a_n <= 1'b1;
                obf_b_n <= 1'b1;
                intr_a  <= 1'b0;
                intr_b  <= 1'b0;
                inte_a  <= 1'b0;
                inte_b  <= 1'b0;
            end else begin
                if (wr_pc) pc_q <= (pc_q & owned) | (D_IN[7:0] & ~owned);
                if (wr_bsr) begin
                    if (mode_a && bsr_bit == inte_a_pos) inte_a <= D_IN[0];
                    else if (mode_b && bsr_bit == 3'd2)  inte_b <= D_IN[0];
                    else if (!owned[bsr_bit])            pc_q[bsr_bit] <= D_IN[0];
                end

                // Clears are issued before sets so a coincident set wins
                if (mode_a) begin
                    if (pa_in_dir) begin
                        if (rd_rise_a) ibf_a  <= 1'b0;
                        if (rd_fall_a) intr_a <= 1'b0;
                        if (hs_fall[0]) begin
                            pa_q  <= PA_IN;
                            ibf_a <= 1'b1;
                        end
                        if (hs_rise[0] && ibf_a && inte_a) intr_a <= 1'b1;
                    end else begin
                        if (hs_fall[1]) obf_a_n <= 1'b1;
                        if (wr_pa) begin
                            pa_q    <= D_IN;
                            obf_a_n <= 1'b0;
                            intr_a  <= 1'b0;
                        end
                        if (hs_rise[1] && obf_a_n && inte_a) intr_a <= 1'b1;
                    end
                end else if (wr_pa && !pa_in_dir) begin
                    pa_q <= D_IN;
                end

                if (mode_b) begin
                    if (pb_in_dir) begin
                        if (rd_rise_b) ibf_b  <= 1'b0;
                        if (rd_fall_b) intr_b <= 1'b0;
                        if (hs_fall[2]) begin
                            pb_q  <= PB_IN;
                            ibf_b <= 1'b1;
                        end
                        if (hs_rise[2] && ibf_b && inte_b) intr_b <= 1'b1;
                    end else begin
                        if (hs_fall[2]) obf_b_n <= 1'b1;
                        if (wr_pb) begin
                            pb_q    <= D_IN;
                            obf_b_n <= 1'b0;
                            intr_b  <= 1'b0;
                        end
                        if (hs_rise[2] && obf_b_n && inte_b) intr_b <= 1'b1;
                    end
                end else if (wr_pb && !pb_in_dir) begin
                    pb_q <= D_IN;
                end
            end
        end
    end

    always_comb begin
        PC_OE  = pc_oe_m0;
        PC_OUT = pc_q;
        pc_rd  = (pc_q & pc_oe_m0) | (PC_IN & ~pc_oe_m0);
        if (mode_a) begin
            if (pa_in_dir) begin
                PC_OE[4]  = 1'b0;
                PC_OE[5]  = 1'b1;
                PC_OUT[5] = ibf_a;
                pc_rd[5]  = ibf_a;
                pc_rd[4]  = inte_a;
            end else begin
                PC_OE[6]  = 1'b0;
                PC_OE[7]  = 1'b1;
                PC_OUT[7] = obf_a_n;
                pc_rd[7]  = obf_a_n;
                pc_rd[6]  = inte_a;
            end
            PC_OE[3]  = 1'b1;
            PC_OUT[3] = intr_a;
            pc_rd[3]  = intr_a;
        end
        if (mode_b) begin
            PC_OE[2]  = 1'b0;
            PC_OE[1]  = 1'b1;
            PC_OE[0]  = 1'b1;
            PC_OUT[1] = pb_in_dir ? ibf_b : obf_b_n;
            PC_OUT[0] = intr_b;
            pc_rd[2]  = inte_b;
            pc_rd[1]  = pb_in_dir ? ibf_b : obf_b_n;
            pc_rd[0]  = intr_b;
        end
    end

    always_comb begin
        rdata = '0;
        case (A)
            2'b00:   rdata = (pa_in_dir && !mode_a) ? PA_IN : pa_q;
            2'b01:   rdata = (pb_in_dir && !mode_b) ? PB_IN : pb_q;
            2'b10:   rdata[7:0] = pc_rd;
            default: rdata[7:0] = ctrl;
        endcase
    end

    assign D_OE   = ~CS_n & ~RD_n;
    assign D_OUT  = D_OE ? rdata : '0;
    assign PA_OUT = pa_q;
    assign PB_OUT = pb_q;
    assign PA_OE  = ~pa_in_dir;
    assign PB_OE  = ~pb_in_dir;
    assign INTR_A = intr_a;
    assign INTR_B = intr_b;

endmodule
